// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared state encoding and constants for the SPI register slave
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        DATA = 2'd2
    } state_t;

    localparam int SPI_ADDR_W = 7;
    localparam int SPI_RW_BIT = 7;

    // Register indices used by the game configuration logic.
    localparam int REG_SPEED  = 0;
    localparam int REG_PADDLE = 1;
    localparam int REG_COLOUR = 2;
    localparam int REG_SOUND  = 3;

endpackage

// File: rtl/pin_sync.sv
// rtl/pin_sync.sv - 2-FF synchroniser for one asynchronous pin
// Ports: clk, rst (async active-high), pin (async in), sync (synchronised out).
// RESET_VAL is the idle level of the pin, so no false edge appears after reset.
module pin_sync #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic sync
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= RESET_VAL;
            sync <= RESET_VAL;
        end else begin
            meta <= pin;
            sync <= meta;
        end
    end

endmodule

// File: rtl/spi_reg_slave.sv
// rtl/spi_reg_slave.sv - SPI mode-0 slave decoding {rw,addr}+data frames into a register file
// Ports: clk, rst (async active-high); sck_pin, ss_pin, mosi_pin (async SPI pins);
//        miso, miso_en (SPI out); regs_flat (reg i at [8*i+7:8*i]);
//        wr_stb, wr_addr, wr_data (1-clk pulse per accepted write).
// Build option: SPI_AUTOINC_EN enables address auto-increment across burst data bytes.
module spi_reg_slave
    import spi_pkg::*;
#(
    parameter int NUM_REGS = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    sck_pin,
    input  logic                    ss_pin,
    input  logic                    mosi_pin,
    output logic                    miso,
    output logic                    miso_en,
    output logic [NUM_REGS*8-1:0]   regs_flat,
    output logic                    wr_stb,
    output logic [SPI_ADDR_W-1:0]   wr_addr,
    output logic [7:0]              wr_data
);

    logic sck_s, ss_s, mosi_s;
    logic sck_d, ss_d;

    pin_sync #(.RESET_VAL(1'b0)) u_sync_sck  (.clk(clk), .rst(rst), .pin(sck_pin),  .sync(sck_s));
    pin_sync #(.RESET_VAL(1'b1)) u_sync_ss   (.clk(clk), .rst(rst), .pin(ss_pin),   .sync(ss_s));
    pin_sync #(.RESET_VAL(1'b0)) u_sync_mosi (.clk(clk), .rst(rst), .pin(mosi_pin), .sync(mosi_s));

    state_t                  state, next_state;
    logic [2:0]              bit_cnt;
    logic [6:0]              rx;
    logic [7:0]              tx;
    logic [SPI_ADDR_W-1:0]   addr;
    logic                    rw;
    logic [7:0]              regs [NUM_REGS];

    logic                    sck_rise, sck_fall, ss_rise, ss_fall;
    logic                    sck_act, byte_done, data_active, wr_en, mapped;
    logic [7:0]              rx_byte, rd_data;

    assign sck_rise = sck_s & ~sck_d;
    assign sck_fall = ~sck_s & sck_d;
    assign ss_rise  = ss_s & ~ss_d;
    assign ss_fall  = ~ss_s & ss_d;

    // An ss rise in the same cycle as an sck rise wins: the sck edge is dropped.
    assign sck_act   = (state != IDLE) && !ss_rise;
    assign rx_byte   = {rx, mosi_s};
    assign byte_done = sck_act && sck_rise && (bit_cnt == 3'd7);

`ifdef SPI_AUTOINC_EN
    assign data_active = 1'b1;
`else
    // Only the first data byte after the command byte is acted on.
    logic first;
    assign data_active = first;
`endif

    always_comb begin
        rd_data = 8'h00;
        mapped  = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (addr == SPI_ADDR_W'(i)) begin
                rd_data = regs[i];
                mapped  = 1'b1;
            end
        end
    end

    assign wr_en   = byte_done && (state == DATA) && !rw && data_active && mapped;
    assign miso    = (state == DATA) && tx[7];
    assign miso_en = ~ss_s;

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign regs_flat[8*g +: 8] = regs[g];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (ss_fall) next_state = CMD;
            CMD:     if (ss_rise) next_state = IDLE;
                     else if (byte_done) next_state = DATA;
            DATA:    if (ss_rise) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sck_d   <= 1'b0;
            ss_d    <= 1'b1;
            bit_cnt <= 3'd0;
            rx      <= 7'd0;
            tx      <= 8'h00;
            addr    <= '0;
            rw      <= 1'b0;
            wr_stb  <= 1'b0;
            wr_addr <= '0;
            wr_data <= 8'h00;
`ifndef SPI_AUTOINC_EN
            first   <= 1'b0;
`endif
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= 8'h00;
        end else begin
            sck_d  <= sck_s;
            ss_d   <= ss_s;
            wr_stb <= 1'b0;
            if (!sck_act) begin
                // Deselect (or idle) discards any partial byte.
                bit_cnt <= 3'd0;
                tx      <= 8'h00;
            end else if (sck_rise) begin
                rx      <= rx_byte[6:0];
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    if (state == CMD) begin
                        rw   <= rx_byte[SPI_RW_BIT];
                        addr <= rx_byte[SPI_ADDR_W-1:0];
`ifndef SPI_AUTOINC_EN
                        first <= 1'b1;
`endif
                    end else begin
                        if (wr_en) begin
                            wr_stb  <= 1'b1;
                            wr_addr <= addr;
                            wr_data <= rx_byte;
                            for (int i = 0; i < NUM_REGS; i++) begin
                                if (addr == SPI_ADDR_W'(i)) regs[i] <= rx_byte;
                            end
                        end
`ifdef SPI_AUTOINC_EN
                        addr <= addr + 1'b1;
`else
                        first <= 1'b0;
`endif
                    end
                end
            end else if (sck_fall && state == DATA) begin
                // First fall of a byte presents the new read data; later falls shift it out.
                if (bit_cnt == 3'd0) begin
                    tx <= (rw && data_active) ? rd_data : 8'h00;
                end else begin
                    tx <= {tx[6:0], 1'b0};
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_reg_slave.sv
// tb/tb_spi_reg_slave.sv - randomized self-checking bench for spi_reg_slave
module tb_spi_reg_slave;
    import spi_pkg::*;

    localparam int NREGS = 8;
`ifdef SPI_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              sck_pin, ss_pin, mosi_pin;
    logic              miso, miso_en;
    logic [NREGS*8-1:0] regs_flat;
    logic              wr_stb;
    logic [6:0]        wr_addr;
    logic [7:0]        wr_data;

    spi_reg_slave #(.NUM_REGS(NREGS)) dut (
        .clk(clk), .rst(rst), .sck_pin(sck_pin), .ss_pin(ss_pin), .mosi_pin(mosi_pin),
        .miso(miso), .miso_en(miso_en), .regs_flat(regs_flat),
        .wr_stb(wr_stb), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    logic [7:0]  model_regs [NREGS];
    logic [7:0]  frame_q [$];
    logic        miso_bits [$];
    logic [14:0] stb_log [$];
    logic [14:0] exp_stb [$];

    always @(negedge clk) begin
        if (!rst && wr_stb) stb_log.push_back({wr_addr, wr_data});
    end

    function automatic logic [63:0] model_flat();
        logic [63:0] f = '0;
        for (int i = 0; i < NREGS; i++) f[8*i +: 8] = model_regs[i];
        return f;
    endfunction

    task automatic spi_xfer(input int nbits, input bit raise_ss);
        logic [7:0] b;
        miso_bits.delete();
        stb_log.delete();
        @(negedge clk);
        ss_pin = 1'b0;
        repeat (6) @(negedge clk);
        check("miso_en_selected", 64'(miso_en), 64'd1);
        for (int n = 0; n < nbits; n++) begin
            b = frame_q[n / 8];
            mosi_pin = b[7 - (n % 8)];
            repeat (5) @(negedge clk);
            miso_bits.push_back(miso);
            sck_pin = 1'b1;
            repeat (5) @(negedge clk);
            sck_pin = 1'b0;
        end
        repeat (5) @(negedge clk);
        if (raise_ss) begin
            ss_pin = 1'b1;
            repeat (8) @(negedge clk);
            check("miso_en_released", 64'(miso_en), 64'd0);
        end
    endtask

    // Sends the frame, then checks miso, write strobes and register contents
    // against the frame-level rules applied to the reference register array.
    task automatic run_frame(input string tag, input int nbits);
        int          nbytes;
        bit          rd;
        logic [6:0]  a, ak;
        logic [7:0]  got_b;
        logic [7:0]  exp_miso [$];
        nbytes = nbits / 8;
        exp_stb.delete();
        rd = frame_q[0][7];
        a  = frame_q[0][6:0];
        exp_miso.push_back(8'h00);
        for (int k = 1; k < nbytes; k++) begin
            bit active;
            active = AUTOINC || (k == 1);
            ak = AUTOINC ? 7'(a + 7'(k - 1)) : a;
            if (rd) begin
                exp_miso.push_back((active && ak < NREGS) ? model_regs[ak] : 8'h00);
            end else if (active && ak < NREGS) begin
                model_regs[ak] = frame_q[k];
                exp_stb.push_back({ak, frame_q[k]});
            end
        end
        spi_xfer(nbits, 1'b1);
        for (int k = 0; k < nbytes; k++) begin
            if (k == 0 || rd) begin
                for (int j = 0; j < 8; j++) got_b[7 - j] = miso_bits[8*k + j];
                check({tag, "_miso"}, 64'(got_b), 64'(exp_miso[k]));
            end
        end
        check({tag, "_stb_cnt"}, 64'(stb_log.size()), 64'(exp_stb.size()));
        for (int i = 0; i < stb_log.size() && i < exp_stb.size(); i++)
            check({tag, "_stb"}, 64'(stb_log[i]), 64'(exp_stb[i]));
        check({tag, "_regs"}, regs_flat, model_flat());
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_regs"},    regs_flat,        64'd0);
        check({tag, "_miso"},    64'(miso),        64'd0);
        check({tag, "_miso_en"}, 64'(miso_en),     64'd0);
        check({tag, "_wr_stb"},  64'(wr_stb),      64'd0);
        check({tag, "_wr_addr"}, 64'(wr_addr),     64'd0);
        check({tag, "_wr_data"}, 64'(wr_data),     64'd0);
    endtask

    initial begin
        rst = 1'b1; sck_pin = 1'b0; ss_pin = 1'b1; mosi_pin = 1'b0;
        for (int i = 0; i < NREGS; i++) model_regs[i] = 8'h00;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        repeat (4) @(negedge clk);

        frame_q = '{8'h02, 8'hA5};
        run_frame("wr_colour", 16);
        frame_q = '{8'h80 | 8'(REG_COLOUR), 8'h00};
        run_frame("rd_colour", 16);

        // Aborted write: command plus five data bits, then deselect.
        frame_q = '{8'h03, 8'hF8};
        run_frame("partial", 13);
        frame_q = '{8'h01, 8'h6C};
        run_frame("after_partial", 16);

        frame_q = '{8'h7E, 8'h55};
        run_frame("wr_unmapped", 16);
        frame_q = '{8'hFE, 8'h00};
        run_frame("rd_unmapped", 16);

        frame_q = '{8'h00, 8'h11, 8'h22, 8'h33};
        run_frame("burst_wr", 32);
        frame_q = '{8'h80, 8'h00, 8'h00, 8'h00};
        run_frame("burst_rd", 32);

        for (int t = 0; t < 20; t++) begin
            int     sel, len;
            logic [6:0] ad;
            logic [7:0] cb;
            sel = $urandom_range(0, 11);
            ad  = (sel == 10) ? 7'h7E : (sel == 11) ? 7'h7F : 7'(sel);
            len = $urandom_range(2, 4);
            cb  = {1'($urandom_range(0, 1)), ad};
            frame_q.delete();
            frame_q.push_back(cb);
            for (int k = 1; k < len; k++) frame_q.push_back(8'($urandom));
            run_frame("rand", len * 8);
        end

        // Reset during byte 2 of a write to the paddle register.
        frame_q = '{8'(REG_PADDLE), 8'h77};
        spi_xfer(12, 1'b0);
        rst = 1'b1;
        ss_pin = 1'b1;
        sck_pin = 1'b0;
        @(negedge clk);
        check_reset_outputs("mid_rst");
        for (int i = 0; i < NREGS; i++) model_regs[i] = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        frame_q = '{8'(REG_PADDLE), 8'h3C};
        run_frame("post_rst_wr", 16);
        frame_q = '{8'h80 | 8'(REG_PADDLE), 8'h00};
        run_frame("post_rst_rd", 16);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
